// File: rtl/sync_fifo_param.sv
// Synchronous single-clock FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode
// (registered read or first-word-fall-through).
module sync_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   EN,
  input  logic                   WR,
  input  logic [WIDTH-1:0]       dataIn,
  input  logic                   RD,
  input  logic                   CLR_ERR,
  output logic [WIDTH-1:0]       dataOut,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic                   AEMPTY,
  output logic                   AFULL,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF,
  output logic                   UNF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] dout_q;
  logic             dout_load;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_set;
  logic             unf_set;

  // Status flags are pure decodes of the registered occupancy, so they
  // settle one cycle after the edge that changed the count.
  assign EMPTY  = (count == '0);
  assign FULL   = (count == CW'(DEPTH));
  assign AEMPTY = (count <= CW'(AE_LEVEL));
  assign AFULL  = (count >= CW'(AF_LEVEL));
  assign COUNT  = count;

  // A write into a full FIFO is still accepted when a read frees the head
  // slot on the same edge; both pointers then address the same entry.
  assign rd_ok   = EN & RD & ~EMPTY;
  assign wr_ok   = EN & WR & (~FULL | rd_ok);
  assign ovf_set = EN & WR & FULL & ~rd_ok;
  assign unf_set = EN & RD & EMPTY;

  assign head = mem[rptr];

  // FWFT shows the head word directly while data is present and falls back
  // to the last head seen once empty; registered mode loads only on a pop.
  generate
    if (FWFT != 0) begin : g_fwft
      assign dout_load = EN & ~EMPTY;
      assign dataOut   = EMPTY ? dout_q : head;
    end else begin : g_reg
      assign dout_load = rd_ok;
      assign dataOut   = dout_q;
    end
  endgenerate

  // Storage array: no reset, stale words are unreachable once pointers clear.
  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wptr] <= dataIn;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count as is.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
    end
  end

  // Sticky error flags; a fresh error on a clear edge keeps the flag set.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else if (EN) begin
      OVF <= (OVF & ~CLR_ERR) | ovf_set;
      UNF <= (UNF & ~CLR_ERR) | unf_set;
    end
  end

  // Output data register, cleared on reset so dataOut starts at zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)            dout_q <= '0;
    else if (dout_load) dout_q <= head;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: a registered-read and a FWFT instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int W = 32;
  localparam int D = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         EN;
  logic         WR;
  logic         RD;
  logic         CLR_ERR;
  logic [W-1:0] dataIn;

  logic [W-1:0] dataOut0, dataOut1;
  logic         EMPTY0, FULL0, AEMPTY0, AFULL0, OVF0, UNF0;
  logic         EMPTY1, FULL1, AEMPTY1, AFULL1, OVF1, UNF1;
  logic [2:0]   COUNT0, COUNT1;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFO contents, popped words awaiting comparison, flags.
  logic [W-1:0] mq[$];
  logic [W-1:0] sb0[$];
  bit           m_ovf;
  bit           m_unf;

  always #5 Clk = ~Clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_reg (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
    .CLR_ERR(CLR_ERR), .dataOut(dataOut0), .EMPTY(EMPTY0), .FULL(FULL0),
    .AEMPTY(AEMPTY0), .AFULL(AFULL0), .COUNT(COUNT0), .OVF(OVF0), .UNF(UNF0)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
    .CLR_ERR(CLR_ERR), .dataOut(dataOut1), .EMPTY(EMPTY1), .FULL(FULL1),
    .AEMPTY(AEMPTY1), .AFULL(AFULL1), .COUNT(COUNT1), .OVF(OVF1), .UNF(UNF1)
  );

  // Reference model: FIFO behaviour expressed with a queue and occupancy size.
  always @(posedge Clk or posedge Rst) begin
    int n;
    bit rdok;
    bit wrok;
    if (Rst) begin
      mq.delete();
      sb0.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (EN) begin
      n    = mq.size();
      rdok = RD && (n > 0);
      wrok = WR && ((n < D) || rdok);
      m_ovf = (m_ovf && !CLR_ERR) || (WR && (n == D) && !rdok);
      m_unf = (m_unf && !CLR_ERR) || (RD && (n == 0));
      if (rdok) sb0.push_back(mq.pop_front());
      if (wrok) mq.push_back(dataIn);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: after every clock edge or reset assertion, compare both DUTs.
  initial begin
    logic [W-1:0] cur0;
    logic [W-1:0] last1;
    logic [W-1:0] e1;
    int           n;
    cur0  = '0;
    last1 = '0;
    forever begin
      @(posedge Clk or posedge Rst);
      #1;
      if (Rst) begin
        cur0  = '0;
        last1 = '0;
      end
      if (sb0.size() > 0) cur0 = sb0.pop_front();
      n = mq.size();
      if (n > 0) begin
        e1    = mq[0];
        last1 = mq[0];
      end else begin
        e1 = last1;
      end
      chk("dout_reg",    dataOut0,      cur0);
      chk("dout_fwft",   dataOut1,      e1);
      chk("count_reg",   32'(COUNT0),   32'(n));
      chk("count_fwft",  32'(COUNT1),   32'(n));
      chk("empty_reg",   32'(EMPTY0),   32'(n == 0));
      chk("empty_fwft",  32'(EMPTY1),   32'(n == 0));
      chk("full_reg",    32'(FULL0),    32'(n == D));
      chk("full_fwft",   32'(FULL1),    32'(n == D));
      chk("aempty_reg",  32'(AEMPTY0),  32'(n <= 2));
      chk("aempty_fwft", 32'(AEMPTY1),  32'(n <= 2));
      chk("afull_reg",   32'(AFULL0),   32'(n >= D - 2));
      chk("afull_fwft",  32'(AFULL1),   32'(n >= D - 2));
      chk("ovf_reg",     32'(OVF0),     32'(m_ovf));
      chk("ovf_fwft",    32'(OVF1),     32'(m_ovf));
      chk("unf_reg",     32'(UNF0),     32'(m_unf));
      chk("unf_fwft",    32'(UNF1),     32'(m_unf));
    end
  end

  task automatic cyc(bit en, bit wr, bit rd, bit clr, logic [31:0] d);
    EN      = en;
    WR      = wr;
    RD      = rd;
    CLR_ERR = clr;
    dataIn  = d;
    @(negedge Clk);
  endtask

  // Stimulus: directed scenarios, a biased random run, then async reset.
  initial begin
    Rst = 1'b1; EN = 1'b0; WR = 1'b0; RD = 1'b0; CLR_ERR = 1'b0; dataIn = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // fill to full, overflow, drain in order, clear error
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 32'(i));
    cyc(1, 1, 0, 0, 32'd4);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 1, 32'd0);

    // underflow on empty, then clear
    cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 0, 32'd0);
    cyc(1, 0, 0, 1, 32'd0);

    // simultaneous write and read while full
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 32'h100 + 32'(i));
    cyc(1, 1, 1, 0, 32'hA);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 0, 32'd0);

    // fall-through of a single word, then pop it
    cyc(1, 1, 0, 0, 32'h55);
    cyc(1, 0, 0, 0, 32'd0);
    cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 0, 32'd0);

    // ten words streamed through, pointers wrap twice
    cyc(1, 1, 0, 0, 32'd200);
    for (int i = 1; i < 10; i++) cyc(1, 1, 1, 0, 32'd200 + 32'(i));
    cyc(1, 0, 1, 0, 32'd0);

    // enable low: requests and clear ignored
    cyc(1, 1, 0, 0, 32'h77);
    cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 1, 0, 32'd0);
    cyc(0, 1, 1, 1, 32'h99);
    cyc(0, 1, 0, 1, 32'h98);
    cyc(1, 0, 0, 1, 32'd0);

    // random traffic with alternating write-heavy / read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 1) ? 30 : 75;
      cyc($urandom_range(15) != 0,
          $urandom_range(99) < wp,
          $urandom_range(99) < (100 - wp),
          $urandom_range(31) == 0,
          $urandom);
    end

    // asynchronous reset mid-cycle with three words stored
    repeat (5) cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 1, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 32'd300 + 32'(i));
    EN = 1'b0; WR = 1'b0; RD = 1'b0; CLR_ERR = 1'b0;
    #1 Rst = 1'b1;
    #2 Rst = 1'b0;
    @(negedge Clk);
    cyc(1, 1, 0, 0, 32'hBEEF);
    cyc(1, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 0, 32'd0);
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of storage entries (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the occupancy at or above which AFULL asserts (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the occupancy at or below which AEMPTY asserts (1..DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Rst  input  1  reset, asynchronous, active-high.
REQ-008 EN  input  1  global enable; when low, WR/RD/CLR_ERR are ignored and all state holds.
REQ-009 WR  input  1  write request.
REQ-010 dataIn  input  WIDTH  write data, sampled on the accepting edge.
REQ-011 RD  input  1  read request.
REQ-012 CLR_ERR  input  1  clears the sticky OVF/UNF flags.
REQ-013 dataOut  output  WIDTH  read data.
REQ-014 EMPTY / FULL  output  1 each  occupancy == 0 / occupancy == DEPTH.
REQ-015 AEMPTY / AFULL  output  1 each  occupancy <= AE_LEVEL / occupancy >= AF_LEVEL.
REQ-016 COUNT  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 OVF / UNF  output  1 each  sticky overflow / underflow error flags.

Function
REQ-018 Write accepted (wr_ok) SHALL be EN & WR & (!FULL | rd_ok); accepted word stored at write pointer, pointer increments modulo DEPTH.
REQ-019 Read accepted (rd_ok) SHALL be EN & RD & !EMPTY; read pointer increments modulo DEPTH.
REQ-020 Simultaneous wr_ok and rd_ok SHALL leave COUNT unchanged, including when FULL (slot freed and refilled same edge).
REQ-021 WR with EMPTY and RD SHALL accept the write, reject the read, COUNT +1.
REQ-022 COUNT SHALL update on the edge of acceptance: +1 write-only, -1 read-only; all flags combinationally derived from registered COUNT, so they change the cycle after the causing edge.
REQ-023 FWFT=0: dataOut SHALL load the head word on the rd_ok edge (one-cycle latency) and hold otherwise.
REQ-024 FWFT=1: dataOut SHALL always present the head word when !EMPTY (zero-latency); rd_ok pops it; value undefined-but-stable (hold last) when EMPTY.
REQ-025 FWFT=1 SHALL show a word written into an empty FIFO on dataOut the cycle after its write edge.
REQ-026 OVF SHALL set on EN & WR & FULL & !rd_ok; the write is dropped, contents unchanged.
REQ-027 UNF SHALL set on EN & RD & EMPTY; pointers and dataOut unchanged.
REQ-028 OVF/UNF SHALL hold until Rst or an EN & CLR_ERR edge; a new error on the same edge as CLR_ERR SHALL win (flag stays set).
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order strictly first-in first-out across any number of wraps.

Reset
REQ-030 Rst high SHALL immediately clear both pointers, COUNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, OVF=0, UNF=0, dataOut=0, regardless of Clk or EN.
REQ-031 Reset mid-operation SHALL discard all stored words; storage array contents need not be cleared.
REQ-032 First accept SHALL be possible on the first rising edge after Rst deasserts.

Verification
REQ-033 WIDTH=32, DEPTH=4, FWFT=0: reset, write 0,1,2,3 -> FULL=1, COUNT=4, AFULL=1; 5th write -> dropped, OVF=1; four reads -> dataOut 0,1,2,3, each one cycle after its RD edge, EMPTY=1.
REQ-034 Read on empty after reset -> UNF=1, dataOut=0, COUNT=0; CLR_ERR pulse -> UNF=0.
REQ-035 DEPTH=4 full, WR=RD=1 with dataIn=0xA for one edge -> COUNT stays 4, OVF=0, dataOut=oldest word, 0xA becomes last.
REQ-036 FWFT=1: write 0x55 into empty -> dataOut=0x55 next cycle with RD low; RD pulse -> EMPTY=1.
REQ-037 Write 10 words, read 10 interleaved (DEPTH=4) -> pointers wrap twice, output sequence equals input sequence, no error flags.
REQ-038 Assert Rst asynchronously mid-clock with COUNT=3 -> outputs reach reset values before next edge; next write then read returns the new word.
